mem_target_responder: RTL and testbench
=======================================

Name: mem_target_responder

Overview:
- Memory-side responder on the controller's memory bus: answers mem_cs/mem_read/mem_write with mem_ready after a programmable wait-state count.
- Backs the bus with word-organised storage and drives read data onto the shared tristate mem_data bus.
- Serves as the on-chip RAM target and as the memory model for controller-level simulation.

Parameters:
- ADDR_WIDTH, 12, word-address bits; depth = 2**ADDR_WIDTH 32-bit words.
- BASE_ADDR, 32'h00000000, byte base of the window; must be aligned to 4*2**ADDR_WIDTH.
- WAIT_STATES, 2, extra cycles between acceptance and mem_ready (0..15).
- ERR_DATA, 32'hDEADBEEF, read value returned for errored accesses.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_addr  in  32  byte address from controller.
- mem_data  inout  32  shared data bus: sampled on writes, driven only during read response.
- mem_read  in  1  read request level.
- mem_write  in  1  write request level.
- mem_cs  in  1  chip select; a request exists only while high.
- mem_ready  out  1  registered, single-cycle completion strobe.
- mem_err  out  1  registered, high with mem_ready when the access is out of window or has read and write both set.

Behaviour:
- Reset: state=IDLE, mem_ready=0, mem_err=0, wait counter=0, mem_data released (Z). Storage contents are not reset.
- States: IDLE, WAIT, RESPOND, HOLD.
- IDLE:
  - Accept when mem_cs && (mem_read || mem_write).
  - Latch word index = (mem_addr-BASE_ADDR)[ADDR_WIDTH+1:2]; mem_addr[1:0] is ignored.
  - Latch op, write data (mem_data), and error = out-of-window || (mem_read && mem_write).
  - Counter loads WAIT_STATES.
  - Next state is WAIT if WAIT_STATES>0, else RESPOND.
- WAIT:
  - Counter decrements each cycle; at 1, go to RESPOND.
  - If mem_cs drops, abort: go to IDLE, no write, no ready.
- RESPOND (exactly 1 cycle):
  - mem_ready=1; mem_err = latched error.
  - Write with no error: storage updated at the end of this cycle.
  - Read: data (or ERR_DATA if errored) driven onto mem_data.
- HOLD (exactly 1 cycle):
  - mem_ready=0; keep driving read data. The controller consumes data one cycle after it sees ready.
  - Then go to IDLE.
- Latency: acceptance edge to mem_ready high is WAIT_STATES+1 cycles; minimum 1.
- A request still asserted after HOLD is treated as a new access.
- Tristate rule: drive mem_data only when state ∈ {RESPOND, HOLD} && latched op=read && mem_read && mem_cs. Otherwise Z, so there is never contention with controller write drive.
- Errored write: no storage update; mem_ready and mem_err both pulse.
- Read-after-write to the same word on the next access returns the new data; no forwarding is needed because the commit precedes the next acceptance.
- Controller timeout (7 wait cycles): WAIT_STATES ≥7 is legal but the controller may complete without data. Documented, not checked.
- rst_n assertion mid-access: immediate return to IDLE, bus released, pending write dropped.

Decomposition:
- Package mem_target_pkg: state encoding constants (IDLE/WAIT/RESPOND/HOLD), ERR_DATA default, address-in-window function.
- Sub-module mem_target_ram: single-port synchronous RAM, 32-bit wide, depth 2**ADDR_WIDTH, write-enable + registered read. The read is issued on acceptance so data is ready at RESPOND.

Test Plan:
- WAIT_STATES=2: write 0x12345678 to 0x00000010, then read 0x00000010 -> mem_ready on cycle 3 after acceptance for each; read drives 0x12345678 in RESPOND and HOLD; mem_err=0.
- WAIT_STATES=0: read 0x00000004 after writing 0xA5A5A5A5 -> mem_ready one cycle after acceptance; mem_data valid for 2 cycles, then Z.
- Abort: start write of 0xFFFFFFFF to 0x20; drop mem_cs in WAIT -> no mem_ready; subsequent read of 0x20 returns the prior value.
- Out-of-window read at BASE_ADDR+4*2**ADDR_WIDTH -> mem_ready=1 and mem_err=1 together; mem_data=0xDEADBEEF; storage untouched.
- mem_read and mem_write both high on 0x8, write data 0x55 -> mem_err pulse; a later read of 0x8 shows old contents.
- Reset mid-WAIT with rst_n low for 1 cycle -> mem_ready=0, mem_data=Z immediately; the next access completes normally with full latency.

Source files
------------

// File: rtl/mem_target_pkg.sv
// rtl/mem_target_pkg.sv - shared state encoding, defaults and window check for the memory target
package mem_target_pkg;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_RESPOND = 2'd2;
    localparam logic [1:0] S_HOLD    = 2'd3;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    // Offset is (addr - base); with an aligned base the window is simply offsets below 4*depth.
    function automatic logic addr_in_window(input logic [31:0] offset, input int addr_width);
        return (offset >> (addr_width + 2)) == 32'd0;
    endfunction

endpackage

// File: rtl/mem_target_responder_if.sv
// rtl/mem_target_responder_if.sv - controller-to-memory request/completion signals
interface mem_target_responder_if;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic        mem_cs;
    logic        mem_ready;
    logic        mem_err;

    modport master (
        output mem_addr, mem_read, mem_write, mem_cs,
        input  mem_ready, mem_err
    );

    modport slave (
        input  mem_addr, mem_read, mem_write, mem_cs,
        output mem_ready, mem_err
    );
endinterface

// File: rtl/mem_target_ram.sv
// rtl/mem_target_ram.sv - single-port 32-bit synchronous RAM with registered read
module mem_target_ram #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  we,
    input  logic [31:0]           wdata,
    input  logic                  re,
    output logic [31:0]           rdata
);

    logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_target_responder.sv
// rtl/mem_target_responder.sv - wait-stated memory target answering the controller bus from on-chip RAM
module mem_target_responder
    import mem_target_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] ERR_DATA    = ERR_DATA_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    mem_target_responder_if.slave        bus,
    inout  wire  [31:0]                  mem_data
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    logic [1:0]            state, state_d;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic                  op_read_q;
    logic                  err_q;
    logic [31:0]           wdata_q;
    logic                  ready_q;
    logic                  err_out_q;

    logic [31:0]           offset;
    logic [ADDR_WIDTH-1:0] new_idx;
    logic                  new_err;
    logic                  accept;
    logic                  drive;
    logic [31:0]           ram_rdata;

    assign offset  = bus.mem_addr - BASE_ADDR;
    assign new_idx = offset[ADDR_WIDTH+1:2];
    assign new_err = !addr_in_window(offset, ADDR_WIDTH) || (bus.mem_read && bus.mem_write);
    assign accept  = bus.mem_cs && (bus.mem_read || bus.mem_write);

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_d = (WS == 4'd0) ? S_RESPOND : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!bus.mem_cs) begin
                    state_d = S_IDLE;
                end else if (cnt == 4'd1) begin
                    state_d = S_RESPOND;
                end
            end
            S_RESPOND: state_d = S_HOLD;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            idx_q     <= '0;
            op_read_q <= 1'b0;
            err_q     <= 1'b0;
            wdata_q   <= 32'd0;
            ready_q   <= 1'b0;
            err_out_q <= 1'b0;
        end else begin
            state     <= state_d;
            ready_q   <= (state_d == S_RESPOND);
            // With zero wait states the error is latched on the same edge it must appear.
            err_out_q <= (state_d == S_RESPOND) && ((state == S_IDLE) ? new_err : err_q);
            if (state == S_IDLE && accept) begin
                idx_q     <= new_idx;
                op_read_q <= bus.mem_read && !bus.mem_write;
                err_q     <= new_err;
                wdata_q   <= mem_data;
                cnt       <= WS;
            end else if (state == S_WAIT) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Read is launched at acceptance so the registered RAM output is valid by RESPOND.
    mem_target_ram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .addr  ((state == S_IDLE) ? new_idx : idx_q),
        .we    (state == S_RESPOND && !op_read_q && !err_q),
        .wdata (wdata_q),
        .re    (state == S_IDLE && accept),
        .rdata (ram_rdata)
    );

    assign drive = (state == S_RESPOND || state == S_HOLD) && op_read_q
                   && bus.mem_read && bus.mem_cs;

    assign mem_data      = drive ? (err_q ? ERR_DATA : ram_rdata) : 32'bz;
    assign bus.mem_ready = ready_q;
    assign bus.mem_err   = err_out_q;

endmodule

// File: tb/tb_mem_target_responder.sv
// tb/tb_mem_target_responder.sv - directed bench for mem_target_responder with 2 and 0 wait states
module tb_mem_target_responder;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic        rd, wr, oe;
    logic [31:0] wdata;
    logic        cs_a, cs_b;
    bit          sel;
    int          checks;
    int          errors;

    tri1 [31:0] data_a;
    tri1 [31:0] data_b;

    mem_target_responder_if if_a ();
    mem_target_responder_if if_b ();

    assign if_a.mem_addr  = addr;
    assign if_a.mem_read  = rd;
    assign if_a.mem_write = wr;
    assign if_a.mem_cs    = cs_a;
    assign if_b.mem_addr  = addr;
    assign if_b.mem_read  = rd;
    assign if_b.mem_write = wr;
    assign if_b.mem_cs    = cs_b;

    assign data_a = (oe && !sel) ? wdata : 32'bz;
    assign data_b = (oe &&  sel) ? wdata : 32'bz;

    mem_target_responder #(.WAIT_STATES(2)) dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (if_a),
        .mem_data (data_a)
    );

    mem_target_responder #(.WAIT_STATES(0)) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (if_b),
        .mem_data (data_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic cur_ready();
        return sel ? if_b.mem_ready : if_a.mem_ready;
    endfunction

    function automatic logic cur_err();
        return sel ? if_b.mem_err : if_a.mem_err;
    endfunction

    function automatic logic [31:0] cur_data();
        return sel ? data_b : data_a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; the released bus reads all ones through the tri1 pull.
    task automatic access(input bit s, input logic [31:0] a, input logic r, input logic w,
                          input logic [31:0] d, input int exp_lat, input logic exp_err,
                          input logic [31:0] exp_rd, input bit chk_rd, input string tag);
        int n;
        bit got;
        sel = s; addr = a; rd = r; wr = w; wdata = d; oe = w;
        cs_a = !s; cs_b = s;
        n = 0; got = 0;
        while (!got && n < 16) begin
            @(negedge clk);
            n++;
            got = cur_ready();
        end
        chk({tag, ":latency"}, 32'(n), 32'(exp_lat));
        chk({tag, ":err"}, {31'd0, cur_err()}, {31'd0, exp_err});
        if (chk_rd) chk({tag, ":respond_data"}, cur_data(), exp_rd);
        @(negedge clk);
        chk({tag, ":hold_ready"}, {31'd0, cur_ready()}, 32'd0);
        if (chk_rd) chk({tag, ":hold_data"}, cur_data(), exp_rd);
        cs_a = 0; cs_b = 0; rd = 0; wr = 0; oe = 0;
        @(negedge clk);
        chk({tag, ":released"}, cur_data(), 32'hFFFF_FFFF);
    endtask

    initial begin
        int hits;
        checks = 0; errors = 0;
        rst_n = 0; addr = 0; rd = 0; wr = 0; oe = 0; wdata = 0;
        cs_a = 0; cs_b = 0; sel = 0;
        repeat (3) @(negedge clk);
        chk("reset:a_ready", {31'd0, if_a.mem_ready}, 32'd0);
        chk("reset:a_err", {31'd0, if_a.mem_err}, 32'd0);
        chk("reset:a_data", data_a, 32'hFFFF_FFFF);
        chk("reset:b_ready", {31'd0, if_b.mem_ready}, 32'd0);
        chk("reset:b_data", data_b, 32'hFFFF_FFFF);
        rst_n = 1;
        @(negedge clk);

        access(0, 32'h10, 0, 1, 32'h1234_5678, 3, 0, 0, 0, "a_wr10");
        access(0, 32'h10, 1, 0, 0, 3, 0, 32'h1234_5678, 1, "a_rd10");
        access(0, 32'h13, 1, 0, 0, 3, 0, 32'h1234_5678, 1, "a_rd13_lowbits");
        access(0, 32'h20, 0, 1, 32'h0BAD_F00D, 3, 0, 0, 0, "a_wr20");
        access(0, 32'h08, 0, 1, 32'h0000_0011, 3, 0, 0, 0, "a_wr08");
        access(0, 32'h00, 0, 1, 32'hCAFE_0001, 3, 0, 0, 0, "a_wr00");

        sel = 0; addr = 32'h20; wr = 1; wdata = 32'hFFFF_FFFF; oe = 1; cs_a = 1;
        @(negedge clk);
        cs_a = 0; wr = 0; oe = 0;
        hits = 0;
        repeat (6) begin
            @(negedge clk);
            if (if_a.mem_ready) hits++;
        end
        chk("abort:no_ready", 32'(hits), 32'd0);
        access(0, 32'h20, 1, 0, 0, 3, 0, 32'h0BAD_F00D, 1, "a_rd20_after_abort");

        access(0, 32'h4000, 1, 0, 0, 3, 1, 32'hDEAD_BEEF, 1, "a_oow_rd");
        access(0, 32'h4000, 0, 1, 32'h0000_0077, 3, 1, 0, 0, "a_oow_wr");
        access(0, 32'h00, 1, 0, 0, 3, 0, 32'hCAFE_0001, 1, "a_rd00_untouched");

        access(0, 32'h08, 1, 1, 32'h0000_0055, 3, 1, 0, 0, "a_rw08_both");
        access(0, 32'h08, 1, 0, 0, 3, 0, 32'h0000_0011, 1, "a_rd08_old");

        sel = 0; addr = 32'h10; rd = 1; cs_a = 1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("midreset:ready_now", {31'd0, if_a.mem_ready}, 32'd0);
        chk("midreset:data_now", data_a, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("midreset:ready_after", {31'd0, if_a.mem_ready}, 32'd0);
        chk("midreset:data_after", data_a, 32'hFFFF_FFFF);
        rst_n = 1; cs_a = 0; rd = 0;
        @(negedge clk);
        access(0, 32'h10, 1, 0, 0, 3, 0, 32'h1234_5678, 1, "a_rd10_after_reset");

        access(1, 32'h04, 0, 1, 32'hA5A5_A5A5, 1, 0, 0, 0, "b_wr04");
        access(1, 32'h04, 1, 0, 0, 1, 0, 32'hA5A5_A5A5, 1, "b_rd04");
        access(1, 32'h4000, 1, 0, 0, 1, 1, 32'hDEAD_BEEF, 1, "b_oow_rd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
